contador_bcd_display: RTL and testbench

CONTADOR_BCD_DISPLAY -- requirements
Module: contador_bcd_display

---
 rtl/contador_pkg.sv | 19 +
 rtl/seg7_decoder.sv | 29 ++
 rtl/contador_bcd_display.sv | 133 +++++++++++++
 tb/tb_contador_bcd_display.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared constants for the BCD counter/display: nibble width and 7-segment codes.
package contador_pkg;

    localparam int unsigned BCD_W = 4;

    // Segment bit order is {dp,g,f,e,d,c,b,a}, active high
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-7-segment decoder with a blank override.
module seg7_decoder
    import contador_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic             blank_i,
    output logic [7:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            unique case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/contador_bcd_display.sv
// Up/down BCD counter with prescaled step, load, and multiplexed 7-segment scan.
// Define CONTADOR_BLANK_EN to blank leading-zero digits on the display.
module contador_bcd_display
    import contador_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned SCAN_DIV   = 50_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        up_dn,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
    output logic [7:0]                  segmentos,
    output logic [NUM_DIGITS-1:0]       sel_seg,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic                        wrap
);

    localparam int unsigned CW = BCD_W * NUM_DIGITS;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d, stepped, load_clean;
    logic [TW-1:0]         pre_q, pre_d;
    logic [SW-1:0]         scan_div_q, scan_div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] is_term, carry_in;
    logic [BCD_W-1:0]      digits [NUM_DIGITS];
    logic                  tick, scan_tick, blank;

    // is_term: digit at 9 (up) or 0 (down); a digit steps when all lower digits are terminal
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] cur, ld;
        assign cur        = cnt_q[i*BCD_W +: BCD_W];
        assign ld         = load_val[i*BCD_W +: BCD_W];
        assign digits[i]  = cur;
        assign is_term[i] = up_dn ? (cur == 4'd9) : (cur == 4'd0);
        assign load_clean[i*BCD_W +: BCD_W] = (ld > 4'd9) ? 4'd0 : ld;

        if (i == 0) begin : g_lsd
            assign carry_in[i] = 1'b1;
        end else begin : g_upper
            assign carry_in[i] = &is_term[i-1:0];
        end

        always_comb begin
            stepped[i*BCD_W +: BCD_W] = cur;
            if (carry_in[i]) begin
                if (up_dn) begin
                    stepped[i*BCD_W +: BCD_W] = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
                end else begin
                    stepped[i*BCD_W +: BCD_W] = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
                end
            end
        end
    end

    assign tick = en && (pre_q == TICK_MAX);

    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_clean;
            pre_d = '0;
        end else if (tick) begin
            cnt_d  = stepped;
            pre_d  = '0;
            wrap_d = &is_term;
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    assign scan_tick  = (scan_div_q == SCAN_MAX);
    assign scan_div_d = scan_tick ? '0 : scan_div_q + 1'b1;
    assign idx_d      = !scan_tick ? idx_q : ((idx_q == IDX_MAX) ? '0 : idx_q + 1'b1);

`ifdef CONTADOR_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        assign lead_zero[i] = ~|cnt_q[CW-1:i*BCD_W];
    end
    assign blank = (idx_q != '0) && lead_zero[idx_q];
`else
    assign blank = 1'b0;
`endif

    seg7_decoder u_seg7_decoder (
        .bcd_i   (digits[idx_q]),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    assign sel_d = NUM_DIGITS'(1) << idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            pre_q      <= '0;
            scan_div_q <= '0;
            idx_q      <= '0;
            wrap_q     <= 1'b0;
            sel_q      <= NUM_DIGITS'(1);
            seg_q      <= SEG_0;
        end else begin
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            scan_div_q <= scan_div_d;
            idx_q      <= idx_d;
            wrap_q     <= wrap_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign count_bcd = cnt_q;
    assign wrap      = wrap_q;
    assign sel_seg   = sel_q;
    assign segmentos = seg_q;

endmodule

// File: tb/tb_contador_bcd_display.sv
// Directed bench for contador_bcd_display with NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2.
module tb_contador_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [7:0]  segmentos;
    logic [3:0]  sel_seg;
    logic [15:0] count_bcd;
    logic        wrap;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    contador_bcd_display #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .SCAN_DIV   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .segmentos (segmentos),
        .sel_seg   (sel_seg),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    // Inputs change and outputs are sampled on the falling edge
    task automatic do_load(input logic [15:0] v);
        en = 1'b0;
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL reset_count: got %h want 0000", count_bcd);
        end
        n_checks++;
        if (sel_seg !== 4'b0001) begin
            n_fail++; $display("FAIL reset_sel: got %b want 0001", sel_seg);
        end
        n_checks++;
        if (segmentos !== 8'h3F) begin
            n_fail++; $display("FAIL reset_seg: got %h want 3f", segmentos);
        end
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap);
        end
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (wrap !== 1'b0) begin
                n_fail++; $display("FAIL up40_wrap cycle %0d: got %b want 0", k, wrap);
            end
        end
        n_checks++;
        if (count_bcd !== 16'h0010) begin
            n_fail++; $display("FAIL up40_count: got %h want 0010", count_bcd);
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [15:0] exp_cnt;
        do_load(16'h9998);
        n_checks++;
        if (count_bcd !== 16'h9998) begin
            n_fail++; $display("FAIL wrap_up_load: got %h want 9998", count_bcd);
        end
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_cnt = (k < 4) ? 16'h9998 : ((k < 8) ? 16'h9999 : 16'h0000);
            n_checks++;
            if (count_bcd !== exp_cnt || wrap !== (k == 8)) begin
                n_fail++;
                $display("FAIL wrap_up cycle %0d: got %h/%b want %h/%b",
                         k, count_bcd, wrap, exp_cnt, (k == 8));
            end
        end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wrap !== 1'b0 || count_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_up_after: got %h/%b want 0000/0", count_bcd, wrap);
        end
        // Carry across two digits
        do_load(16'h0199);
        en = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h0200 || wrap !== 1'b0) begin
            n_fail++; $display("FAIL carry_0199: got %h/%b want 0200/0", count_bcd, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        logic [15:0] exp_cnt;
        do_load(16'h0000);
        en = 1'b1;
        up_dn = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_cnt = (k < 4) ? 16'h0000 : ((k < 8) ? 16'h9999 : 16'h9998);
            n_checks++;
            if (count_bcd !== exp_cnt || wrap !== (k == 4)) begin
                n_fail++;
                $display("FAIL wrap_dn cycle %0d: got %h/%b want %h/%b",
                         k, count_bcd, wrap, exp_cnt, (k == 4));
            end
        end
        en = 1'b0;
        up_dn = 1'b1;
    endtask

    task automatic test_load();
        do_load(16'h12AF);
        n_checks++;
        if (count_bcd !== 16'h1200) begin
            n_fail++; $display("FAIL load_sanitize: got %h want 1200", count_bcd);
        end
        do_load(16'hA0B9);
        n_checks++;
        if (count_bcd !== 16'h0009) begin
            n_fail++; $display("FAIL load_sanitize2: got %h want 0009", count_bcd);
        end
        // Load coinciding with a tick at all-9s: no step, no wrap
        do_load(16'h9999);
        en = 1'b1;
        up_dn = 1'b1;
        repeat (3) @(negedge clk);
        load = 1'b1;
        load_val = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (count_bcd !== 16'h9999 || wrap !== 1'b0) begin
            n_fail++; $display("FAIL load_on_tick: got %h/%b want 9999/0", count_bcd, wrap);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h9999 || wrap !== 1'b0) begin
            n_fail++; $display("FAIL load_clears_pre: got %h/%b want 9999/0", count_bcd, wrap);
        end
        @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h0000 || wrap !== 1'b1) begin
            n_fail++; $display("FAIL load_then_step: got %h/%b want 0000/1", count_bcd, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel [8];
        logic [7:0] exp_seg [8];
        logic [3:0] prev;
        logic [7:0] lz_code;
        bit         found;
`ifdef CONTADOR_BLANK_EN
        lz_code = 8'h00;
`else
        lz_code = 8'h3F;
`endif
        exp_sel = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8};
        exp_seg = '{8'h5B, 8'h5B, 8'h66, 8'h66, lz_code, lz_code, lz_code, lz_code};
        do_load(16'h0042);
        repeat (2) @(negedge clk);
        prev = sel_seg;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (prev == 4'b1000 && sel_seg == 4'b0001) found = 1'b1;
            prev = sel_seg;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL scan_sync: got sel %b want 8->1 transition", sel_seg);
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (k > 0) @(negedge clk);
                n_checks++;
                if (sel_seg !== exp_sel[k] || segmentos !== exp_seg[k]) begin
                    n_fail++;
                    $display("FAIL scan slot %0d: got %b/%h want %b/%h",
                             k, sel_seg, segmentos, exp_sel[k], exp_seg[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_load(16'h0000);
        en = 1'b1;
        up_dn = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h0001) begin
            n_fail++; $display("FAIL mid_pre: got %h want 0001", count_bcd);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (count_bcd !== 16'h0000 || sel_seg !== 4'b0001 || segmentos !== 8'h3F
            || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%b/%h/%b want 0000/0001/3f/0",
                     count_bcd, sel_seg, segmentos, wrap);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL mid_hold3: got %h want 0000", count_bcd);
        end
        @(negedge clk);
        n_checks++;
        if (count_bcd !== 16'h0001) begin
            n_fail++; $display("FAIL mid_step4: got %h want 0001", count_bcd);
        end
        en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_scan();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
